// File: rtl/hpdcache_dir_init_sweep.sv
// HPDcache directory front-end: zero-fills every set of all ways after reset and on flush,
// otherwise forwards requests to the directory SRAMs. Optional macro: HPDCACHE_DIR_INIT_SKIP_EN.
module hpdcache_dir_init_sweep #(
  parameter int unsigned SETS    = 64,
  parameter int unsigned WAYS    = 4,
  parameter int unsigned ADDR_W  = 6,
  parameter int unsigned ENTRY_W = 28
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      flush_req_i,
  output logic                      flush_ack_o,
  output logic                      init_done_o,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic [ADDR_W-1:0]         req_addr_i,
  input  logic [WAYS-1:0]           req_cs_i,
  input  logic [WAYS-1:0]           req_we_i,
  input  logic [WAYS*ENTRY_W-1:0]   req_wentry_i,
  output logic                      rsp_valid_o,
  output logic [WAYS*ENTRY_W-1:0]   rsp_rentry_o,
  output logic [ADDR_W-1:0]         dir_addr_o,
  output logic [WAYS-1:0]           dir_cs_o,
  output logic [WAYS-1:0]           dir_we_o,
  output logic [WAYS*ENTRY_W-1:0]   dir_wentry_o,
  input  logic [WAYS*ENTRY_W-1:0]   dir_rentry_i
);

  typedef enum logic {SWEEP, READY} state_e;

  localparam logic [ADDR_W-1:0] LAST_SET = ADDR_W'(SETS - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              is_flush_q, is_flush_d;
  logic              flush_ack_q, flush_ack_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              init_done_q, init_done_d;
  logic              ready;
  logic              accept;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
`ifdef HPDCACHE_DIR_INIT_SKIP_EN
      state_q     <= READY;
      init_done_q <= 1'b1;
`else
      state_q     <= SWEEP;
      init_done_q <= 1'b0;
`endif
      cnt_q       <= '0;
      is_flush_q  <= 1'b0;
      flush_ack_q <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_done_q <= init_done_d;
      cnt_q       <= cnt_d;
      is_flush_q  <= is_flush_d;
      flush_ack_q <= flush_ack_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    is_flush_d   = is_flush_q;
    flush_ack_d  = 1'b0;
    init_done_d  = init_done_q;
    rsp_valid_d  = 1'b0;
    ready        = 1'b0;
    accept       = 1'b0;
    dir_addr_o   = req_addr_i;
    dir_cs_o     = '0;
    dir_we_o     = '0;
    dir_wentry_o = req_wentry_i;

    case (state_q)
      SWEEP: begin
        dir_addr_o   = cnt_q;
        dir_cs_o     = '1;
        dir_we_o     = '1;
        dir_wentry_o = '0;
        cnt_d        = cnt_q + ADDR_W'(1);
        if (cnt_q == LAST_SET) begin
          cnt_d       = '0;
          state_d     = READY;
          flush_ack_d = is_flush_q;
          is_flush_d  = 1'b0;
          init_done_d = 1'b1;
        end
      end
      READY: begin
        // The ack cycle masks the still-high flush level so it is not restarted immediately
        ready  = !(flush_req_i && !flush_ack_q);
        accept = req_valid_i && ready;
        if (accept) begin
          dir_cs_o = req_cs_i;
          dir_we_o = req_we_i;
        end
        rsp_valid_d = accept && (|req_cs_i) && !(|(req_cs_i & req_we_i));
        if (flush_req_i && !flush_ack_q) begin
          state_d    = SWEEP;
          is_flush_d = 1'b1;
          cnt_d      = '0;
        end
      end
      default: state_d = SWEEP;
    endcase

    if (!rst_ni) begin
      dir_cs_o = '0;
      dir_we_o = '0;
    end
  end

  assign req_ready_o  = ready;
  assign flush_ack_o  = flush_ack_q;
  assign init_done_o  = init_done_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_rentry_o = dir_rentry_i;

endmodule

// File: doc/hpdcache_dir_init_sweep.md
Name: hpdcache_dir_init_sweep

Overview:
- Front-end controller for the per-way directory SRAMs of the HPDcache memory array.
- After reset it sweeps every set and writes all-zero (invalid) entries into all ways.
- It runs the same sweep on an invalidate-all (flush) request.
- Outside a sweep it forwards directory requests to the array and flags one-cycle-latency read responses.

Parameters:
- SETS, 64, number of directory sets swept; 1 <= SETS <= 2**ADDR_W.
- WAYS, 4, number of directory ways (one SRAM each).
- ADDR_W, 6, directory SRAM address width.
- ENTRY_W, 28, width of one directory entry.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  synchronous active-low reset.
- flush_req_i  in  1  invalidate-all request; level, held until flush_ack_o.
- flush_ack_o  out  1  one-cycle pulse when the flush sweep completes.
- init_done_o  out  1  high once the reset sweep has finished.
- req_valid_i  in  1  directory access request.
- req_ready_o  out  1  request accepted when valid && ready.
- req_addr_i  in  ADDR_W  set index.
- req_cs_i  in  WAYS  per-way chip select.
- req_we_i  in  WAYS  per-way write enable.
- req_wentry_i  in  WAYS*ENTRY_W  write entries, way w at [w*ENTRY_W +: ENTRY_W].
- rsp_valid_o  out  1  read data valid on rsp_rentry_o.
- rsp_rentry_o  out  WAYS*ENTRY_W  read entries.
- dir_addr_o  out  ADDR_W  to array directory address.
- dir_cs_o  out  WAYS  to array chip selects.
- dir_we_o  out  WAYS  to array write enables.
- dir_wentry_o  out  WAYS*ENTRY_W  to array write entries.
- dir_rentry_i  in  WAYS*ENTRY_W  from array; SRAM read latency is 1 cycle.

Behaviour:
- Single clock domain; reset is synchronous, active-low, on clk_i/rst_ni.
- State register: SWEEP, READY. Also a sweep counter cnt[ADDR_W], a flag is_flush, and a registered flush_ack_o.
- Reset values: state=SWEEP, cnt=0, is_flush=0, flush_ack_o=0, rsp_valid_o=0, init_done_o=0.
- While rst_ni=0, dir_cs_o and dir_we_o are forced to 0, regardless of state.
- SWEEP:
  - dir_addr_o=cnt, dir_cs_o=dir_we_o=all ones, dir_wentry_o=0.
  - req_ready_o=0.
  - cnt increments each cycle.
  - When cnt==SETS-1: cnt wraps to 0 and the next state is READY. If is_flush, flush_ack_o=1 next cycle and is_flush clears. init_done_o is set next cycle (sticky until reset).
- A sweep takes exactly SETS cycles. The first write happens in the first cycle with rst_ni=1.
- READY:
  - dir_* outputs are driven combinationally from req_*.
  - dir_cs_o and dir_we_o are gated by req_valid_i && req_ready_o.
  - req_ready_o = !(flush_req_i && !flush_ack_o).
- Flush take-over:
  - In READY with flush_req_i=1 and flush_ack_o=0: next state SWEEP, is_flush=1, cnt=0.
  - A request presented in that same cycle is not accepted.
  - flush_req_i is ignored in the ack cycle. This requires the requester to drop it on ack; if it is still high one cycle later, a new flush starts.
- flush_req_i during the reset sweep is ignored until READY. It is then serviced by a separate full sweep.
- rsp_valid_o is registered. It is 1 in the cycle after an accepted request with |req_cs_i && !(|(req_cs_i & req_we_i)); otherwise 0.
- rsp_rentry_o = dir_rentry_i (pass-through); data is meaningful only when rsp_valid_o=1.
- A request with cs=0 is accepted and has no effect.
- Mixed read/write across ways counts as a write: no response.
- Reset mid-sweep or mid-flush:
  - The sweep restarts at set 0 with is_flush=0.
  - A pending flush is never acked; the requester re-issues it.
  - init_done_o stays 0 until the new sweep completes.
- rsp_valid_o is never set in, or in the cycle after, a SWEEP cycle, except for a request accepted in READY.

Optional Feature:
- HPDCACHE_DIR_INIT_SKIP_EN, simulation only.
- Defined: the reset state is READY with init_done_o=1 after reset. No reset sweep is performed and the array contents are left as-is. Flush sweeps are unchanged.
- Undefined: behaviour as above.

Test Plan:
- Release reset (defaults) -> dir_we_o=4'b1111, dir_wentry_o=0, dir_addr_o=0..63 on consecutive cycles. req_ready_o=0 throughout. init_done_o=1 and req_ready_o=1 in cycle 64.
- After init, write way 2 set 5 entry 28'hABCDEF (cs=we=4'b0100), then read set 5 cs=4'b0100 -> rsp_valid_o=1 one cycle later with way 2 field = 28'hABCDEF, using the array model.
- In READY, assert flush_req_i and req_valid_i in cycle T -> request not accepted; sweep addresses 0..63 in T+1..T+64; flush_ack_o=1 only in T+65. A subsequent read of set 5 returns 0.
- Assert flush_req_i at sweep set 10 of the reset sweep -> init_done_o at cycle 64, then a second 64-cycle sweep, exactly one flush_ack_o pulse.
- rst_ni low for 1 cycle at flush set 30 -> no flush_ack_o; init_done_o=0; sweep restarts at 0 and init_done_o rises 64 cycles after release.
- With HPDCACHE_DIR_INIT_SKIP_EN defined -> init_done_o=1 and req_ready_o=1 in the first cycle after reset; no dir_we_o activity.
